// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the RAM arbiter and its refresh timer.
package ram_arb_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      REFRESH,
      ACK
   } state_e;

   typedef logic port_idx_t;

endpackage

// File: rtl/ram_arbiter_refresh_timer.sv
// Free-running refresh interval counter with pending and overrun tracking.
module refresh_timer
   import ram_arb_pkg::*;
#(
   parameter int unsigned REFRESH_INTERVAL = 7800
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic refresh_taken_i,
   output logic pending_o,
   output logic overrun_o
);

   localparam int unsigned CW = $clog2(REFRESH_INTERVAL);
   localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          ovr_q, ovr_d;
   logic          expire;

   always_comb begin
      expire = (cnt_q == '0);
      cnt_d  = expire ? RELOAD : cnt_q - 1'b1;
      pend_d = (pend_q & ~refresh_taken_i) | expire;
      ovr_d  = ovr_q | (expire & pend_q & ~refresh_taken_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= RELOAD;
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   // Expiry counts as pending at once so a same-cycle request loses.
   assign pending_o = pend_q | expire;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM controller between two requesters
// and a periodic refresh, with a per-operation timeout.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned REFRESH_INTERVAL = 7800,
   parameter int unsigned TIMEOUT          = 255
) (
   input  logic              clock,
   input  logic              resetin,
   input  logic              rq0_req,
   input  logic              rq0_write,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [DATA_W-1:0] rq0_wdata,
   output logic              rq0_ack,
   output logic              rq0_err,
   output logic [DATA_W-1:0] rq0_rdata,
   input  logic              rq1_req,
   input  logic              rq1_write,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [DATA_W-1:0] rq1_wdata,
   output logic              rq1_ack,
   output logic              rq1_err,
   output logic [DATA_W-1:0] rq1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_refresh,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done_n,
   output logic              refresh_overrun,
   output logic              refresh_err
);

   localparam int unsigned TW =
      (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e            state_q, state_d;
   port_idx_t         last_q, last_d;
   port_idx_t         gnt_q, gnt_d;
   port_idx_t         pick;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [1:0]        ack_q, ack_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              rf_q, rf_d;
   logic              err_q, err_d;
   logic              rferr_q, rferr_d;
   logic              pick_wr;
   logic              tmo_hit;
   logic              rf_pend;
   logic              taken;

   refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_timer (
      .clk_i           (clock),
      .rst_i           (resetin),
      .refresh_taken_i (taken),
      .pending_o       (rf_pend),
      .overrun_o       (refresh_overrun)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      tmo_d    = tmo_q + 1'b1;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ack_d    = '0;
      err_d    = 1'b0;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      rf_d     = 1'b0;
      rferr_d  = rferr_q;
      taken    = 1'b0;
      pick     = (rq0_req & rq1_req) ? ~last_q : rq1_req;
      pick_wr  = pick ? rq1_write : rq0_write;
      tmo_hit  = (tmo_q == TMO_LAST);
      unique case (state_q)
         IDLE: begin
            if (mem_done_n) begin
               if (rf_pend) begin
                  state_d = REFRESH;
                  rf_d    = 1'b1;
                  tmo_d   = '0;
               end else if (rq0_req | rq1_req) begin
                  state_d = BUSY;
                  gnt_d   = pick;
                  last_d  = pick;
                  tmo_d   = '0;
                  addr_d  = pick ? rq1_addr : rq0_addr;
                  wdata_d = pick ? rq1_wdata : rq0_wdata;
                  wr_d    = pick_wr;
                  rd_d    = ~pick_wr;
               end
            end
         end
         BUSY: begin
            rd_d = rd_q;
            wr_d = wr_q;
            // A done in the timeout cycle still counts as success.
            if (!mem_done_n || tmo_hit) begin
               state_d      = ACK;
               rd_d         = 1'b0;
               wr_d         = 1'b0;
               ack_d[gnt_q] = 1'b1;
               err_d        = mem_done_n;
               if (!mem_done_n && rd_q) begin
                  if (gnt_q) rdata1_d = mem_rdata;
                  else       rdata0_d = mem_rdata;
               end
            end
         end
         REFRESH: begin
            rf_d = 1'b1;
            if (!mem_done_n || tmo_hit) begin
               state_d = IDLE;
               rf_d    = 1'b0;
               taken   = 1'b1;
               if (mem_done_n) rferr_d = 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge resetin) begin
      if (resetin) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or posedge resetin) begin
      if (resetin) begin
         last_q   <= 1'b1;
         gnt_q    <= 1'b0;
         tmo_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         rf_q     <= 1'b0;
         rferr_q  <= 1'b0;
      end else begin
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         tmo_q    <= tmo_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         rf_q     <= rf_d;
         rferr_q  <= rferr_d;
      end
   end

   assign rq0_ack     = ack_q[0];
   assign rq1_ack     = ack_q[1];
   assign rq0_err     = ack_q[0] & err_q;
   assign rq1_err     = ack_q[1] & err_q;
   assign rq0_rdata   = rdata0_q;
   assign rq1_rdata   = rdata1_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_refresh = rf_q;
   assign refresh_err = rferr_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single `ramcontroller` instance between two CPU-side requesters (port 0: instruction fetch, port 1: load/store) and a built-in periodic refresh scheduler. It sits between the CPU memory stage and `ramcontroller`, and is the only block that drives the controller's `address`/`read`/`write`/`refresh` inputs. Requesters are served round-robin; a pending refresh pre-empts both at the next idle point. A per-operation timeout guarantees forward progress if the controller never signals done.

## Interface
- `REFRESH_INTERVAL`, default 7800: cycles between refresh requests (≥ 2).
- `TIMEOUT`, default 255: max cycles in BUSY/REFRESH before abort (≥ 1).
- `clock`  in  1  single clock; all logic on rising edge.
- `resetin`  in  1  asynchronous, active-high reset.
- `rq0_req`, `rq1_req`  in  1  request level; held until ack.
- `rq0_write`, `rq1_write`  in  1  1 = write, 0 = read; stable while req high.
- `rq0_addr`, `rq1_addr`  in  64  byte address; stable while req high.
- `rq0_wdata`, `rq1_wdata`  in  64  write data; stable while req high.
- `rq0_ack`, `rq1_ack`  out  1  one-cycle completion pulse.
- `rq0_err`, `rq1_err`  out  1  valid with ack; 1 = timed out.
- `rq0_rdata`, `rq1_rdata`  out  64  read data; valid with ack, held until next ack on that port.
- `mem_address`  out  64  to controller `address`.
- `mem_wdata`  out  64  to controller `datain`.
- `mem_read`, `mem_write`  out  1  command levels.
- `mem_refresh`  out  1  refresh command level.
- `mem_rdata`  in  64  from controller `dataout`.
- `mem_done_n`  in  1  active-low completion from controller.
- `refresh_overrun`  out  1  sticky: refresh interval expired while the previous refresh was still pending.
- `refresh_err`  out  1  sticky: a refresh timed out.

## Operation
- States: IDLE, BUSY, REFRESH, ACK.
- IDLE: waits until `mem_done_n` = 1 (controller released). Then, in priority order:
  - refresh pending → REFRESH;
  - otherwise any request → BUSY.
- Round-robin: `last_grant` resets to 1, so port 0 wins the first tie. When both ports request, grant the port ≠ `last_grant`. A single requester is always granted. Update `last_grant` on entry to BUSY.
- Entry to BUSY registers the granted port's addr, wdata, and write into the `mem_*` outputs and asserts exactly one of `mem_read`/`mem_write`. Outputs are held constant throughout BUSY.
- BUSY: on `mem_done_n` = 0, capture `mem_rdata` into the granted port's rdata (reads only) → ACK with err = 0. If `TIMEOUT` cycles elapse first → ACK with err = 1 and rdata unchanged.
- ACK: one cycle. `rqN_ack` is high for the granted port only, with err. `mem_read`, `mem_write` and `mem_refresh` are all 0. Requests are not sampled. Next state is IDLE. A req still high in the following IDLE is a new request.
- REFRESH: `mem_refresh` = 1 until `mem_done_n` = 0 → IDLE and clear pending. On timeout → IDLE, clear pending, set `refresh_err`. No ack is issued for refresh.
- Refresh timer:
  - down-counter reloads `REFRESH_INTERVAL-1`;
  - at 0, sets pending and reloads;
  - runs freely in all states;
  - if it hits 0 while pending is already set, `refresh_overrun` is set (pending stays 1).

## Timing
- Reset values: all outputs 0; state IDLE; `last_grant` = 1; timer = `REFRESH_INTERVAL-1`; pending = 0; both sticky flags 0.
- Requests are sampled in IDLE at edge N. Commands are visible from cycle N+1.
- `mem_done_n` is sampled at edge M. ack is high during cycle M+1.
- Minimum request-to-ack latency is 2 cycles (done_n low in the first BUSY cycle).
- Back-to-back on one port is a 3-cycle period (BUSY, ACK, IDLE).
- Timeout counter: clears on entry to BUSY/REFRESH and increments each cycle. Abort fires when count = `TIMEOUT-1` and done_n = 1.
- Simultaneous events:
  - refresh becoming pending in the same cycle as a request in IDLE → refresh wins;
  - done_n low in the timeout cycle → success (err = 0).
- `resetin` mid-operation: all commands drop asynchronously, no ack is produced, and any in-flight request is lost (requester must re-issue).

## Structure
- Package `ram_arb_pkg`:
  - state enum (IDLE/BUSY/REFRESH/ACK);
  - `ADDR_W` = 64, `DATA_W` = 64;
  - port-index type.
- Sub-module `refresh_timer`: counter, pending, and overrun logic, parameterised by `REFRESH_INTERVAL`, with a `refresh_taken` input. Arbiter FSM, grant logic and timeout counter live in the top.

## Test plan
- Single read: port 0 req, addr 0x1000; model drops done_n 3 cycles later with rdata 0xDEADBEEF → `mem_read` 1 for 3 cycles; `rq0_ack` one cycle after; `rq0_rdata` = 0xDEADBEEF; err 0.
- Contention: both ports hold req for 4 transactions → grants 0,1,0,1; `mem_write`/`mem_read` match each port's write bit; no cycle with both commands high.
- Refresh pre-emption: `REFRESH_INTERVAL` = 20, continuous port 1 traffic → `mem_refresh` appears after the in-flight op completes, before the next grant; repeats every ~20 cycles.
- Overrun: `REFRESH_INTERVAL` = 4, done_n held high during refresh with `TIMEOUT` = 10 → `refresh_overrun` = 1, `refresh_err` = 1; arbiter returns to IDLE.
- Timeout: port 0 write, done_n never low, `TIMEOUT` = 8 → `rq0_ack` = 1, `rq0_err` = 1 exactly 9 cycles after the req sample; rdata unchanged.
- Async reset mid-BUSY: assert `resetin` for 1 cycle → all `mem_*` commands 0 immediately, no ack; after release, port 0 wins a tie.
